tpm_pin_loader: RTL

Upstream feeder for the TPM checker. It collects an 8-character PIN from a byte-wide valid/ready source into an internal buffer, then replays the PIN to the checker's `clk/rst/data` port with the exact cycle discipline the checker needs, and samples `lock`. It also reports pass/fail per attempt and enforces a timed lockout after repeated failures.

---
 rtl/tpm_pin_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tpm_pin_loader.sv
// Collects a PIN from a valid/ready byte source and replays it into the TPM checker.
// Reports pass/fail for each attempt and locks the source out after repeated failures.
module tpm_pin_loader #(
    parameter int          PIN_LEN        = 8,
    parameter int          MAX_FAILS      = 3,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_clear,
    output logic       tpm_rst,
    output logic [7:0] tpm_data,
    input  logic       tpm_lock,
    output logic       result_valid,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic       locked_out
);

    localparam int         CW          = $clog2(PIN_LEN + 1);
    localparam int         IW          = $clog2(PIN_LEN);
    localparam logic [3:0] MAX_FAILS_W = 4'(MAX_FAILS);

    typedef enum logic [1:0] {COLLECT, STREAM, CHECK, LOCKOUT} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [IW-1:0]   idx;
    logic [7:0]      pin_buf [PIN_LEN];
    logic [31:0]     lock_cnt;
    logic            take;
    logic [3:0]      fail_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // The checker only behaves if tpm_rst is low for exactly the 8 stream
    // cycles plus the check cycle, so rst overrides every decoded output.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        tpm_rst    = 1'b1;
        tpm_data   = 8'h00;
        take       = 1'b0;
        fail_next  = fail_count + 4'd1;
        case (state)
            COLLECT: begin
                in_ready = (count < CW'(PIN_LEN));
            end
            STREAM: begin
                tpm_rst  = 1'b0;
                tpm_data = pin_buf[idx];
                if (idx == IW'(PIN_LEN - 1)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                tpm_rst = 1'b0;
                if (tpm_lock) begin
                    state_next = COLLECT;
                end else if (fail_next == MAX_FAILS_W) begin
                    state_next = LOCKOUT;
                end else begin
                    state_next = COLLECT;
                end
            end
            LOCKOUT: begin
                if (lock_cnt == 32'd1) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
        if (rst) begin
            in_ready = 1'b0;
            tpm_rst  = 1'b1;
            tpm_data = 8'h00;
        end
        take = (state == COLLECT) && in_valid && in_ready && !in_clear;
        if (take && (count == CW'(PIN_LEN - 1))) begin
            state_next = STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            pin_buf[count[IW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            idx          <= '0;
            fail_count   <= 4'd0;
            pass         <= 1'b0;
            result_valid <= 1'b0;
            locked_out   <= 1'b0;
            lock_cnt     <= 32'd0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    // A clear in the same cycle as a handshake drops that byte.
                    if (in_clear) begin
                        count <= '0;
                    end else if (take) begin
                        count <= count + CW'(1);
                    end
                end
                STREAM: begin
                    if (idx == IW'(PIN_LEN - 1)) begin
                        idx <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                CHECK: begin
                    pass         <= tpm_lock;
                    result_valid <= 1'b1;
                    count        <= '0;
                    if (tpm_lock) begin
                        fail_count <= 4'd0;
                    end else begin
                        fail_count <= fail_next;
                        if (fail_next == MAX_FAILS_W) begin
                            locked_out <= 1'b1;
                            lock_cnt   <= LOCKOUT_CYCLES;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == 32'd1) begin
                        fail_count <= 4'd0;
                        locked_out <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - 32'd1;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule
